// File: rtl/clock_pkg.sv
// clock_pkg
//   Shared definitions for the time-of-day counter:
//   - state_t       : mode encoding driven onto STATE
//   - *_MAX         : BCD terminal values for each time field
//   - DEF_*         : default prescaler / blink rates
//   - bcd_inc()     : two-digit BCD increment with wrap at a BCD maximum
package clock_pkg;

  typedef enum logic [1:0] {
    ST_NORMAL   = 2'b00,
    ST_SET_HOUR = 2'b01,
    ST_SET_MIN  = 2'b10
  } state_t;

  localparam logic [7:0] SEC_MAX  = 8'h59;
  localparam logic [7:0] MIN_MAX  = 8'h59;
  localparam logic [7:0] HOUR_MAX = 8'h23;

  localparam int DEF_TICKS_PER_SEC = 100;
  localparam int DEF_BLINK_TICKS   = 50;

  // Values at or above max wrap to 00, so a corrupted value can never
  // walk the tens digit past its bound. Comparing packed BCD as binary
  // is order-preserving for valid BCD.
  function automatic logic [7:0] bcd_inc(input logic [7:0] value,
                                         input logic [7:0] max);
    logic [7:0] result;
    if (value >= max) begin
      result = 8'h00;
    end else if (value[3:0] >= 4'd9) begin
      result = {value[7:4] + 4'd1, 4'd0};
    end else begin
      result = {value[7:4], value[3:0] + 4'd1};
    end
    return result;
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// bcd_mod_counter
//   Two-digit BCD counter that wraps from MAX back to 00.
//   Ports:
//     CLK   in   system clock
//     RST   in   synchronous active-high reset (VALUE -> 00)
//     CLR   in   synchronous clear, takes priority over INC
//     INC   in   advance by one
//     VALUE out  current BCD value
//     CARRY out  INC while VALUE == MAX (combinational), feeds next field
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter logic [7:0] MAX = SEC_MAX
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CLR,
  input  logic       INC,
  output logic [7:0] VALUE,
  output logic       CARRY
);

  logic [7:0] r_value;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_value <= 8'h00;
    end else if (CLR) begin
      r_value <= 8'h00;
    end else if (INC) begin
      r_value <= bcd_inc(r_value, MAX);
    end
  end

  assign VALUE = r_value;
  assign CARRY = INC && (r_value == MAX);

endmodule

// File: rtl/clock_time_counter.sv
// clock_time_counter
//   24 h BCD time-of-day counter driven by a 100 Hz clock enable, with a
//   button-driven set mode for hours and minutes and a blink request for
//   the field being edited.
//   Ports:
//     CLK       in   system clock
//     RST       in   synchronous active-high reset
//     CE10      in   one-CLK-wide 100 Hz enable
//     BTN_MODE  in   debounced mode button level
//     BTN_UP    in   debounced increment button level
//     HOUR      out  BCD hours 00-23
//     MIN       out  BCD minutes 00-59
//     SEC       out  BCD seconds 00-59
//     STATE     out  00 NORMAL, 01 SET_HOUR, 10 SET_MIN
//     BLINK     out  blank request for the field being set
module clock_time_counter
  import clock_pkg::*;
#(
  parameter int TICKS_PER_SEC = DEF_TICKS_PER_SEC,
  parameter int BLINK_TICKS   = DEF_BLINK_TICKS
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CE10,
  input  logic       BTN_MODE,
  input  logic       BTN_UP,
  output logic [7:0] HOUR,
  output logic [7:0] MIN,
  output logic [7:0] SEC,
  output logic [1:0] STATE,
  output logic       BLINK
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int BW = $clog2(BLINK_TICKS + 1);

  state_t          r_state;
  logic [PW-1:0]   r_presc;
  logic [BW-1:0]   r_blink_cnt;
  logic            r_blink;
  logic            r_mode_hist;
  logic            r_up_hist;

  logic            w_mode_press;
  logic            w_up_press;
  logic            w_up_act;
  logic            w_normal;
  logic            w_presc_wrap;
  logic            w_blink_wrap;
  logic            w_sec_inc;
  logic            w_sec_clr;
  logic            w_min_inc;
  logic            w_hour_inc;
  logic            w_sec_carry;
  logic            w_min_carry;
  // Midnight rollover has no consumer; the hour field simply wraps.
  logic            w_unused_hour_carry;

  // Rising-edge detect against the previous sampled level.
  assign w_mode_press = BTN_MODE & ~r_mode_hist;
  assign w_up_press   = BTN_UP & ~r_up_hist;
  // MODE wins when both buttons rise on the same edge.
  assign w_up_act     = w_up_press & ~w_mode_press;

  assign w_normal     = (r_state == ST_NORMAL);
  assign w_presc_wrap = (r_presc == PW'(TICKS_PER_SEC - 1));
  assign w_blink_wrap = (r_blink_cnt == BW'(BLINK_TICKS - 1));

  // Time only advances in NORMAL; the carry chain is used only there so
  // set-mode edits never ripple into neighbouring fields.
  assign w_sec_inc  = w_normal & CE10 & w_presc_wrap;
  assign w_sec_clr  = (r_state == ST_SET_MIN) & w_mode_press;
  assign w_min_inc  = (w_normal & w_sec_carry) |
                      ((r_state == ST_SET_MIN) & w_up_act);
  assign w_hour_inc = (w_normal & w_min_carry) |
                      ((r_state == ST_SET_HOUR) & w_up_act);

  bcd_mod_counter #(.MAX(SEC_MAX)) u_sec (
    .CLK   (CLK),
    .RST   (RST),
    .CLR   (w_sec_clr),
    .INC   (w_sec_inc),
    .VALUE (SEC),
    .CARRY (w_sec_carry)
  );

  bcd_mod_counter #(.MAX(MIN_MAX)) u_min (
    .CLK   (CLK),
    .RST   (RST),
    .CLR   (1'b0),
    .INC   (w_min_inc),
    .VALUE (MIN),
    .CARRY (w_min_carry)
  );

  bcd_mod_counter #(.MAX(HOUR_MAX)) u_hour (
    .CLK   (CLK),
    .RST   (RST),
    .CLR   (1'b0),
    .INC   (w_hour_inc),
    .VALUE (HOUR),
    .CARRY (w_unused_hour_carry)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= ST_NORMAL;
      r_presc     <= '0;
      r_blink_cnt <= '0;
      r_blink     <= 1'b0;
      r_mode_hist <= 1'b0;
      r_up_hist   <= 1'b0;
    end else begin
      r_mode_hist <= BTN_MODE;
      r_up_hist   <= BTN_UP;
      case (r_state)
        ST_NORMAL: begin
          // Blink counter is parked at 0 so entering SET_HOUR starts a
          // fresh half-period with BLINK low.
          r_blink_cnt <= '0;
          r_blink     <= 1'b0;
          if (CE10) begin
            r_presc <= w_presc_wrap ? '0 : r_presc + PW'(1);
          end
          if (w_mode_press) begin
            r_state <= ST_SET_HOUR;
          end
        end
        ST_SET_HOUR, ST_SET_MIN: begin
          // Prescaler frozen; blink phase runs continuously across both
          // set states.
          if (CE10) begin
            if (w_blink_wrap) begin
              r_blink_cnt <= '0;
              r_blink     <= ~r_blink;
            end else begin
              r_blink_cnt <= r_blink_cnt + BW'(1);
            end
          end
          if (w_mode_press) begin
            if (r_state == ST_SET_HOUR) begin
              r_state <= ST_SET_MIN;
            end else begin
              // Seconds restart from a clean boundary after editing.
              r_state     <= ST_NORMAL;
              r_presc     <= '0;
              r_blink_cnt <= '0;
              r_blink     <= 1'b0;
            end
          end
        end
        default: begin
          r_state     <= ST_NORMAL;
          r_presc     <= '0;
          r_blink_cnt <= '0;
          r_blink     <= 1'b0;
        end
      endcase
    end
  end

  assign STATE = r_state;
  assign BLINK = r_blink;

endmodule

// File: tb/tb_clock_time_counter.sv
module tb_clock_time_counter;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       CE10 = 1'b0;
  logic       BTN_MODE = 1'b0;
  logic       BTN_UP = 1'b0;
  logic [7:0] HOUR;
  logic [7:0] MIN;
  logic [7:0] SEC;
  logic [1:0] STATE;
  logic       BLINK;

  int n_cmp = 0;
  int n_mis = 0;

  localparam int OP_MODE = 0;
  localparam int OP_UP   = 1;
  localparam int OP_CE   = 2;

  typedef struct {
    int         op;
    int         n;
    logic [7:0] hour;
    logic [7:0] min;
    logic [7:0] sec;
    logic [1:0] st;
    logic       blink;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  clock_time_counter dut (
    .CLK      (CLK),
    .RST      (RST),
    .CE10     (CE10),
    .BTN_MODE (BTN_MODE),
    .BTN_UP   (BTN_UP),
    .HOUR     (HOUR),
    .MIN      (MIN),
    .SEC      (SEC),
    .STATE    (STATE),
    .BLINK    (BLINK)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_time(input string name, input logic [7:0] h, input logic [7:0] m,
                            input logic [7:0] s);
    check({name, " hour"}, HOUR, h);
    check({name, " min"}, MIN, m);
    check({name, " sec"}, SEC, s);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      CE10 = 1'b1;
      step();
      CE10 = 1'b0;
      step();
    end
  endtask

  task automatic press(input logic mode_b, input logic up_b);
    BTN_MODE = mode_b;
    BTN_UP   = up_b;
    step();
    BTN_MODE = 1'b0;
    BTN_UP   = 1'b0;
    step();
  endtask

  // Edit the clock to hh:mm with seconds cleared, starting from NORMAL.
  task automatic set_time(input int hours, input int mins);
    press(1'b1, 1'b0);
    for (int i = 0; i < hours; i++) press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    for (int i = 0; i < mins; i++) press(1'b0, 1'b1);
    press(1'b1, 1'b0);
  endtask

  initial begin
    // Set-mode walk: expected values after each row is applied.
    vecs[0]  = '{OP_MODE, 1,  8'h00, 8'h00, 8'h01, 2'b01, 1'b0};
    vecs[1]  = '{OP_UP,   1,  8'h01, 8'h00, 8'h01, 2'b01, 1'b0};
    vecs[2]  = '{OP_UP,   8,  8'h09, 8'h00, 8'h01, 2'b01, 1'b0};
    vecs[3]  = '{OP_UP,   1,  8'h10, 8'h00, 8'h01, 2'b01, 1'b0};
    vecs[4]  = '{OP_UP,   13, 8'h23, 8'h00, 8'h01, 2'b01, 1'b0};
    vecs[5]  = '{OP_UP,   1,  8'h00, 8'h00, 8'h01, 2'b01, 1'b0};
    vecs[6]  = '{OP_UP,   1,  8'h01, 8'h00, 8'h01, 2'b01, 1'b0};
    vecs[7]  = '{OP_CE,   30, 8'h01, 8'h00, 8'h01, 2'b01, 1'b0};
    vecs[8]  = '{OP_MODE, 1,  8'h01, 8'h00, 8'h01, 2'b10, 1'b0};
    vecs[9]  = '{OP_UP,   59, 8'h01, 8'h59, 8'h01, 2'b10, 1'b0};
    vecs[10] = '{OP_UP,   1,  8'h01, 8'h00, 8'h01, 2'b10, 1'b0};
    vecs[11] = '{OP_UP,   1,  8'h01, 8'h01, 8'h01, 2'b10, 1'b0};
    vecs[12] = '{OP_CE,   20, 8'h01, 8'h01, 8'h01, 2'b10, 1'b1};
    vecs[13] = '{OP_MODE, 1,  8'h01, 8'h01, 8'h00, 2'b00, 1'b0};
    vecs[14] = '{OP_CE,   99, 8'h01, 8'h01, 8'h00, 2'b00, 1'b0};
    vecs[15] = '{OP_CE,   1,  8'h01, 8'h01, 8'h01, 2'b00, 1'b0};

    // Reset held three edges with CE10 pulsing.
    RST  = 1'b1;
    CE10 = 1'b1;
    step();
    check_time("reset edge1", 8'h00, 8'h00, 8'h00);
    check("reset edge1 state", {6'd0, STATE}, 8'h00);
    check("reset edge1 blink", {7'd0, BLINK}, 8'h00);
    CE10 = 1'b0;
    step();
    CE10 = 1'b1;
    step();
    check_time("reset held", 8'h00, 8'h00, 8'h00);
    check("reset held state", {6'd0, STATE}, 8'h00);
    RST  = 1'b0;
    CE10 = 1'b0;
    step();
    $display("reset done: %h:%h:%h state %b blink %b", HOUR, MIN, SEC, STATE, BLINK);

    // First second boundary.
    tick(99);
    check("tick99 sec", SEC, 8'h00);
    CE10 = 1'b1;
    step();
    check("tick100 sec", SEC, 8'h01);
    CE10 = 1'b0;
    step();
    $display("second tick: %h:%h:%h", HOUR, MIN, SEC);

    // Table-driven set-mode walk.
    for (int i = 0; i < NV; i++) begin
      case (vecs[i].op)
        OP_MODE: for (int k = 0; k < vecs[i].n; k++) press(1'b1, 1'b0);
        OP_UP:   for (int k = 0; k < vecs[i].n; k++) press(1'b0, 1'b1);
        default: tick(vecs[i].n);
      endcase
      check_time($sformatf("row%0d", i), vecs[i].hour, vecs[i].min, vecs[i].sec);
      check($sformatf("row%0d state", i), {6'd0, STATE}, {6'd0, vecs[i].st});
      check($sformatf("row%0d blink", i), {7'd0, BLINK}, {7'd0, vecs[i].blink});
      $display("row %0d op %0d x%0d -> %h:%h:%h state %b blink %b",
               i, vecs[i].op, vecs[i].n, HOUR, MIN, SEC, STATE, BLINK);
    end

    // Held UP gives one increment; simultaneous MODE+UP gives MODE only.
    press(1'b1, 1'b0);
    BTN_UP = 1'b1;
    repeat (500) step();
    BTN_UP = 1'b0;
    step();
    check("held up hour", HOUR, 8'h02);
    $display("held up: hour %h", HOUR);
    BTN_MODE = 1'b1;
    BTN_UP   = 1'b1;
    step();
    check("simul state", {6'd0, STATE}, 8'h02);
    check("simul hour", HOUR, 8'h02);
    check("simul min", MIN, 8'h01);
    BTN_MODE = 1'b0;
    BTN_UP   = 1'b0;
    step();
    press(1'b1, 1'b0);
    check("exit setmin state", {6'd0, STATE}, 8'h00);
    press(1'b0, 1'b1);
    check_time("up in normal", 8'h02, 8'h01, 8'h00);
    $display("simultaneous/normal-up: %h:%h:%h state %b", HOUR, MIN, SEC, STATE);

    // Blink phases in SET_HOUR, continuing into SET_MIN.
    press(1'b1, 1'b0);
    check("blink enter", {7'd0, BLINK}, 8'h00);
    tick(49);
    check("blink ce49", {7'd0, BLINK}, 8'h00);
    tick(1);
    check("blink ce50", {7'd0, BLINK}, 8'h01);
    tick(49);
    check("blink ce99", {7'd0, BLINK}, 8'h01);
    tick(1);
    check("blink ce100", {7'd0, BLINK}, 8'h00);
    tick(50);
    check("blink ce150", {7'd0, BLINK}, 8'h01);
    check("blink sec frozen", SEC, 8'h00);
    $display("blink: state %b blink %b", STATE, BLINK);

    // Reset in SET_MIN.
    press(1'b1, 1'b0);
    check("pre-rst state", {6'd0, STATE}, 8'h02);
    RST = 1'b1;
    step();
    check_time("rst in setmin", 8'h00, 8'h00, 8'h00);
    check("rst in setmin state", {6'd0, STATE}, 8'h00);
    check("rst in setmin blink", {7'd0, BLINK}, 8'h00);
    // MODE held through reset acts on the first edge after release.
    BTN_MODE = 1'b1;
    step();
    check("held thru rst state", {6'd0, STATE}, 8'h00);
    RST = 1'b0;
    step();
    check("post-rst press state", {6'd0, STATE}, 8'h01);
    BTN_MODE = 1'b0;
    step();
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    check("back to normal", {6'd0, STATE}, 8'h00);
    $display("mid-set reset: %h:%h:%h state %b", HOUR, MIN, SEC, STATE);

    // Midnight rollover from 23:59:59.
    set_time(23, 59);
    check_time("set 23:59", 8'h23, 8'h59, 8'h00);
    tick(5999);
    check_time("at 23:59:59", 8'h23, 8'h59, 8'h59);
    CE10 = 1'b1;
    step();
    check_time("midnight", 8'h00, 8'h00, 8'h00);
    CE10 = 1'b0;
    step();
    $display("midnight rollover: %h:%h:%h", HOUR, MIN, SEC);

    // Hour tens carry from 09:59:59.
    set_time(9, 59);
    tick(5999);
    check_time("at 09:59:59", 8'h09, 8'h59, 8'h59);
    CE10 = 1'b1;
    step();
    check_time("ten o'clock", 8'h10, 8'h00, 8'h00);
    CE10 = 1'b0;
    step();
    $display("hour tens rollover: %h:%h:%h", HOUR, MIN, SEC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/clock_time_counter.md
Name: clock_time_counter

Overview:
- Time-of-day counter for the digital clock. It is the consumer end of the clock-enable interface.
- Counts CE10 pulses (100 Hz) into seconds, then keeps BCD hours:minutes:seconds in 24 h format.
- Provides a button-driven set mode for hours and minutes.
- Outputs feed the display scanner and blink logic.

Parameters:
- TICKS_PER_SEC, 100, number of CE10 pulses per second. Prescaler wraps at TICKS_PER_SEC-1.
- BLINK_TICKS, 50, number of CE10 pulses per BLINK half-period while in a set state.

Ports:
- CLK  input  1  system clock
- RST  input  1  reset, synchronous, active-high
- CE10  input  1  one-CLK-wide 100 Hz clock enable
- BTN_MODE  input  1  mode button; synchronized, debounced level
- BTN_UP  input  1  increment button; synchronized, debounced level
- HOUR  output  8  BCD hours, 00–23 (tens in [7:4], units in [3:0])
- MIN  output  8  BCD minutes, 00–59
- SEC  output  8  BCD seconds, 00–59
- STATE  output  2  00 = NORMAL, 01 = SET_HOUR, 10 = SET_MIN
- BLINK  output  1  display-blank request for the field being set

Behaviour:
- Clocking and reset:
  - One clock, CLK. All state updates on the rising edge.
  - RST is synchronous and active-high. It overrides everything in the same edge.
  - Reset values: HOUR = 8'h00, MIN = 8'h00, SEC = 8'h00, STATE = NORMAL, BLINK = 0. Prescaler, blink counter and button history registers are all 0.
- Button edge detect:
  - Each button has a history register.
  - A press is recognized on the edge where BTN = 1 and history = 0. Its action is registered on that same edge.
  - Holding a button produces exactly one action. RST clears the history, so a button held through reset acts on the first edge after RST deasserts.
- State machine:
  - A MODE press moves NORMAL → SET_HOUR → SET_MIN → NORMAL. STATE value 11 is illegal and recovers to NORMAL on the next edge.
  - If a MODE press and an UP press land on the same edge, MODE wins and UP is ignored.
- NORMAL:
  - On each CE10, the prescaler increments.
  - On the CE10 where prescaler = TICKS_PER_SEC-1, the prescaler goes to 0 and SEC increments. This takes one CLK of latency after the CE10 sample.
  - Carries: SEC 59 → 00 carries to MIN in the same edge. MIN 59 → 00 carries to HOUR in the same edge. HOUR 23 → 00 wraps with no carry out.
  - 23:59:59 → 00:00:00 completes in a single edge.
  - UP presses are ignored in NORMAL.
- SET_HOUR / SET_MIN:
  - The prescaler and SEC are frozen; CE10 does not advance time.
  - An UP press increments the selected field modulo its range (HOUR 23 → 00, MIN 59 → 00) with no carry into other fields.
  - Leaving SET_MIN (MODE press) clears SEC to 00 and the prescaler to 0 in the same edge.
- BLINK:
  - In a set state, a counter advances on CE10 and BLINK toggles every BLINK_TICKS CE10 pulses.
  - Entering SET_HOUR from NORMAL clears the counter and sets BLINK = 0.
  - The SET_HOUR → SET_MIN transition does not reset the counter.
  - In NORMAL, BLINK = 0 and the counter is held at 0.
- Arithmetic:
  - All digits are BCD. A units digit at 9 rolls to 0 and increments tens.
  - Digits never leave 0–9. Tens digits are bounded at 5 for SEC/MIN and 2 for HOUR.
  - HOUR wraps at 2 / 3 (i.e. 23), not at 29.
- Reset mid-operation: RST while in a set state returns to NORMAL with the time at 00:00:00 on that edge.

Decomposition:
- Package clock_pkg holds:
  - STATE encodings: ST_NORMAL, ST_SET_HOUR, ST_SET_MIN.
  - BCD limits: SEC_MAX = 8'h59, MIN_MAX = 8'h59, HOUR_MAX = 8'h23.
  - Default TICKS_PER_SEC and BLINK_TICKS.
- Sub-module bcd_mod_counter:
  - Two-digit BCD counter with parameter MAX (BCD).
  - Inputs: CLK, RST, CLR, INC.
  - Outputs: VALUE[7:0], and CARRY (combinational, INC && VALUE == MAX).
  - Instantiated three times (SEC, MIN, HOUR). The FSM drives INC and CLR.

Test Plan:
- Reset: assert RST for 3 CLK with CE10 pulsing → HOUR/MIN/SEC = 00, STATE = 00, BLINK = 0 on the first edge and held.
- Second tick: 99 CE10 pulses → SEC = 00. The 100th CE10 → SEC = 01 one CLK later.
- Full rollover:
  - Set the time to 23:59:59 with prescaler at 99, then apply one CE10.
  - Required: 00:00:00 on the next edge.
  - Also check 09:59:59 → 10:00:00.
- Set mode:
  - MODE press, then UP ×25 → STATE = 01 and HOUR goes 00 → 01 → … → 23 → 00 → 01, with MIN unchanged.
  - Then MODE press, UP ×61 → STATE = 10 and MIN ends at 01.
  - Then MODE press → STATE = 00, SEC = 00, and time resumes after 100 CE10.
- Held and simultaneous buttons:
  - BTN_UP held 500 CLK in SET_HOUR → exactly +1.
  - MODE and UP rising on the same edge in SET_HOUR → STATE = 10, HOUR unchanged.
- Blink and mid-set reset:
  - In SET_HOUR, BLINK toggles after CE10 pulses 50, 100 and 150.
  - RST asserted in SET_MIN → STATE = 00, 00:00:00, BLINK = 0 on that edge.
